// File: rtl/scalar_lsu.sv
// Multi-cycle load/store unit: one request at a time, routed to one of NumChan memory channels,
// with sub-word lane steering, load extension, alignment checking and an access timeout.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; captures all request fields on accept
// ACCESS | mem_req_o asserted on the selected channel, waiting for ready
// RESP   | response presented until rsp_ready_i
module scalar_lsu #(
    parameter int DWidth        = 32,
    parameter int NumChan       = 2,
    parameter int TimeoutCycles = 255,
    localparam int ChanW        = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_write_i,
    input  logic [1:0]                  req_size_i,
    input  logic                        req_signed_i,
    input  logic [ChanW-1:0]            req_chan_i,
    input  logic [DWidth-1:0]           req_addr_i,
    input  logic [DWidth-1:0]           req_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [DWidth-1:0]           rsp_rdata_o,
    output logic [1:0]                  rsp_err_o,
    output logic [NumChan-1:0]          mem_req_o,
    output logic                        mem_write_o,
    output logic [DWidth-1:0]           mem_addr_o,
    output logic [DWidth-1:0]           mem_wdata_o,
    output logic [DWidth/8-1:0]         mem_be_o,
    input  logic [NumChan-1:0]          mem_ready_i,
    input  logic [NumChan*DWidth-1:0]   mem_rdata_i
);

    localparam int ByteW = DWidth / 8;
    localparam int OffW  = $clog2(ByteW);
    localparam int CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

    localparam logic [1:0] ErrOk        = 2'd0;
    localparam logic [1:0] ErrMisalign  = 2'd1;
    localparam logic [1:0] ErrBadReq    = 2'd2;
    localparam logic [1:0] ErrTimeout   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              op_write_q;
    logic              op_signed_q;
    logic [1:0]        op_size_q;
    logic [ChanW-1:0]  op_chan_q;
    logic [OffW-1:0]   op_off_q;
    logic [DWidth-1:0] mem_addr_q;
    logic [DWidth-1:0] mem_wdata_q;
    logic [ByteW-1:0]  mem_be_q;
    logic [CntW-1:0]   cnt_q;
    logic [DWidth-1:0] rdata_q;
    logic [1:0]        err_q;

    logic [OffW-1:0]   req_off;
    logic              req_bad;
    logic              misaligned;
    logic [DWidth-1:0] lane_wdata;
    logic [ByteW-1:0]  lane_be;
    logic [DWidth-1:0] sel_rdata;
    logic              sel_ready;
    logic [DWidth-1:0] shifted;
    logic [DWidth-1:0] ld_mask;
    logic              ld_sbit;
    logic [DWidth-1:0] ld_data;
    logic [CntW-1:0]   cnt_inc;
    logic              timed_out;

    assign req_off = req_addr_i[OffW-1:0];
    assign req_bad = ((req_size_i == 2'd3) && (DWidth == 32)) ||
                     (32'(req_chan_i) >= 32'(NumChan));

    always_comb begin
        misaligned = 1'b0;
        case (req_size_i)
            2'd1:    misaligned = req_addr_i[0];
            2'd2:    misaligned = |req_addr_i[1:0];
            2'd3:    misaligned = |req_addr_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        lane_wdata = '0;
        lane_be    = '1;
        if (req_write_i) begin
            case (req_size_i)
                2'd0: begin
                    lane_wdata = {ByteW{req_wdata_i[7:0]}};
                    lane_be    = ByteW'(1) << req_off;
                end
                2'd1: begin
                    lane_wdata = {(ByteW/2){req_wdata_i[15:0]}};
                    lane_be    = ByteW'(3) << req_off;
                end
                2'd2: begin
                    lane_wdata = {(ByteW/4){req_wdata_i[31:0]}};
                    lane_be    = ByteW'(15) << req_off;
                end
                default: begin
                    lane_wdata = req_wdata_i;
                    lane_be    = '1;
                end
            endcase
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NumChan; k++) begin
            if (op_chan_q == ChanW'(k)) sel_rdata = mem_rdata_i[k*DWidth +: DWidth];
        end
    end

    assign sel_ready = |(mem_ready_i & mem_req_o);
    assign shifted   = sel_rdata >> {op_off_q, 3'b000};

    always_comb begin
        ld_mask = '1;
        ld_sbit = 1'b0;
        case (op_size_q)
            2'd0: begin
                ld_mask = DWidth'(8'hFF);
                ld_sbit = shifted[7];
            end
            2'd1: begin
                ld_mask = DWidth'(16'hFFFF);
                ld_sbit = shifted[15];
            end
            2'd2: begin
                ld_mask = DWidth'(32'hFFFF_FFFF);
                ld_sbit = shifted[31];
            end
            default: begin
                ld_mask = '1;
                ld_sbit = 1'b0;
            end
        endcase
    end

    assign ld_data   = (shifted & ld_mask) | ((op_signed_q && ld_sbit) ? ~ld_mask : '0);
    assign cnt_inc   = cnt_q + CntW'(1);
    assign timed_out = (TimeoutCycles != 0) && (cnt_inc == CntW'(TimeoutCycles));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) state_d = (req_bad || misaligned) ? RESP : ACCESS;
            end
            ACCESS: begin
                if (sel_ready || timed_out) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_write_q  <= 1'b0;
            op_signed_q <= 1'b0;
            op_size_q   <= 2'd0;
            op_chan_q   <= '0;
            op_off_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= ErrOk;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_write_q  <= req_write_i;
                        op_signed_q <= req_signed_i;
                        op_size_q   <= req_size_i;
                        op_chan_q   <= req_chan_i;
                        op_off_q    <= req_off;
                        mem_addr_q  <= {req_addr_i[DWidth-1:OffW], {OffW{1'b0}}};
                        mem_wdata_q <= lane_wdata;
                        mem_be_q    <= lane_be;
                        cnt_q       <= '0;
                        rdata_q     <= '0;
                        if (req_bad)         err_q <= ErrBadReq;
                        else if (misaligned) err_q <= ErrMisalign;
                        else                 err_q <= ErrOk;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_inc;
                    // A ready in the timeout cycle still completes the access.
                    if (sel_ready) begin
                        rdata_q <= op_write_q ? '0 : ld_data;
                        err_q   <= ErrOk;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= ErrTimeout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign mem_req_o   = (state_q == ACCESS) ? (NumChan'(1) << op_chan_q) : '0;
    assign mem_write_o = (state_q == ACCESS) && op_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_scalar_lsu.sv
// Directed bench for scalar_lsu (DWidth=32, NumChan=3, TimeoutCycles=4).
module tb_scalar_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [1:0]  req_chan_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic [2:0]  mem_req_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [2:0]  mem_ready_i;
    logic [95:0] mem_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    scalar_lsu #(.DWidth(32), .NumChan(3), .TimeoutCycles(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
        .req_chan_i(req_chan_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives a request for one cycle; returns at the negedge of the first post-accept cycle.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [1:0] ch, input logic [31:0] a, input logic [31:0] wd);
        req_valid_i  = 1'b1;
        req_write_i  = w;
        req_size_i   = sz;
        req_signed_i = sg;
        req_chan_i   = ch;
        req_addr_i   = a;
        req_wdata_i  = wd;
        @(negedge clk_i);
        req_valid_i  = 1'b0;
    endtask

    task automatic ack(input logic [2:0] rdy);
        mem_ready_i = rdy;
        @(negedge clk_i);
        mem_ready_i = 3'b000;
    endtask

    task automatic take_rsp(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_err);
        chk({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
        chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(exp_data));
        chk({tag, "_err"},   64'(rsp_err_o),   64'(exp_err));
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk({tag, "_back_idle"}, 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        int req_cycles;
        int guard;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_write_i  = 1'b0;
        req_size_i   = 2'd0;
        req_signed_i = 1'b0;
        req_chan_i   = 2'd0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        rsp_ready_i  = 1'b0;
        mem_ready_i  = 3'b000;
        mem_rdata_i  = '0;
        repeat (3) @(negedge clk_i);

        chk("rst_mem_req",   64'(mem_req_o),   64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_be",        64'(mem_be_o),    64'd0);
        chk("rst_addr",      64'(mem_addr_o),  64'd0);
        chk("rst_wdata",     64'(mem_wdata_o), 64'd0);
        chk("rst_rdata",     64'(rsp_rdata_o), 64'd0);
        chk("rst_err",       64'(rsp_err_o),   64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);

        // sb to offset 3 of chan 0
        issue(1'b1, 2'd0, 1'b0, 2'd0, 32'h13, 32'hA5);
        chk("sb_req",   64'(mem_req_o),   64'b001);
        chk("sb_write", 64'(mem_write_o), 64'd1);
        chk("sb_be",    64'(mem_be_o),    64'b1000);
        chk("sb_wdata", 64'(mem_wdata_o), 64'hA5A5A5A5);
        chk("sb_addr",  64'(mem_addr_o),  64'h10);
        chk("sb_busy",  64'(req_ready_o), 64'd0);
        ack(3'b001);
        take_rsp("sb", 32'h0, 2'd0);

        // sh to offset 2 of chan 2
        issue(1'b1, 2'd1, 1'b0, 2'd2, 32'h102, 32'hBEEF_1234);
        chk("sh_req",   64'(mem_req_o),   64'b100);
        chk("sh_be",    64'(mem_be_o),    64'b1100);
        chk("sh_wdata", 64'(mem_wdata_o), 64'h12341234);
        chk("sh_addr",  64'(mem_addr_o),  64'h100);
        ack(3'b100);
        take_rsp("sh", 32'h0, 2'd0);

        // lh signed / unsigned from chan 1
        mem_rdata_i[63:32] = 32'h8001_0000;
        issue(1'b0, 2'd1, 1'b1, 2'd1, 32'h2, 32'h0);
        chk("lhs_req",   64'(mem_req_o),   64'b010);
        chk("lhs_write", 64'(mem_write_o), 64'd0);
        chk("lhs_be",    64'(mem_be_o),    64'hF);
        chk("lhs_addr",  64'(mem_addr_o),  64'h0);
        ack(3'b010);
        take_rsp("lhs", 32'hFFFF8001, 2'd0);
        issue(1'b0, 2'd1, 1'b0, 2'd1, 32'h2, 32'h0);
        ack(3'b010);
        take_rsp("lhu", 32'h00008001, 2'd0);

        // lb signed at offset 1, lw from chan 2
        mem_rdata_i[31:0] = 32'h0000_8000;
        issue(1'b0, 2'd0, 1'b1, 2'd0, 32'h1, 32'h0);
        ack(3'b001);
        take_rsp("lbs", 32'hFFFFFF80, 2'd0);
        mem_rdata_i[95:64] = 32'hDEAD_BEEF;
        issue(1'b0, 2'd2, 1'b1, 2'd2, 32'h8, 32'h0);
        chk("lw_addr", 64'(mem_addr_o), 64'h8);
        ack(3'b100);
        take_rsp("lw", 32'hDEADBEEF, 2'd0);

        // error paths: no mem_req, response one cycle after accept
        issue(1'b0, 2'd2, 1'b0, 2'd0, 32'h6, 32'h0);
        chk("mis_req", 64'(mem_req_o), 64'd0);
        take_rsp("mis", 32'h0, 2'd1);
        issue(1'b0, 2'd3, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("size_req", 64'(mem_req_o), 64'd0);
        take_rsp("size", 32'h0, 2'd2);
        issue(1'b1, 2'd0, 1'b0, 2'd3, 32'h0, 32'h0);
        chk("chan_req", 64'(mem_req_o), 64'd0);
        take_rsp("chan", 32'h0, 2'd2);

        // timeout with only non-selected channels ready
        mem_rdata_i[31:0] = 32'h1234_5678;
        issue(1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0);
        mem_ready_i = 3'b110;
        req_cycles = 0;
        guard = 0;
        while (!rsp_valid_o && guard < 20) begin
            if (mem_req_o == 3'b001) req_cycles++;
            guard++;
            @(negedge clk_i);
        end
        mem_ready_i = 3'b000;
        chk("to_bounded", 64'(guard < 20), 64'd1);
        chk("to_req_cycles", 64'(req_cycles), 64'd4);
        take_rsp("to", 32'h0, 2'd3);

        // ready in the 4th access cycle beats the timeout
        issue(1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (3) @(negedge clk_i);
        chk("to4_req", 64'(mem_req_o), 64'b001);
        ack(3'b001);
        take_rsp("to4", 32'h12345678, 2'd0);

        // response back-pressure
        mem_rdata_i[63:32] = 32'h0000_00C3;
        issue(1'b0, 2'd0, 1'b0, 2'd1, 32'h0, 32'h0);
        ack(3'b010);
        mem_rdata_i[63:32] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(rsp_valid_o), 64'd1);
            chk("bp_rdata", 64'(rsp_rdata_o), 64'hC3);
            chk("bp_ready", 64'(req_ready_o), 64'd0);
            @(negedge clk_i);
        end
        take_rsp("bp", 32'hC3, 2'd0);

        // reset mid-access aborts without a response
        issue(1'b0, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("rma_req", 64'(mem_req_o), 64'b001);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rma_req_drop", 64'(mem_req_o), 64'd0);
        rst_ni = 1'b1;
        mem_ready_i = 3'b001;
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o || mem_req_o != 3'b000) req_cycles++;
        end
        mem_ready_i = 3'b000;
        chk("rma_no_rsp", 64'(req_cycles), 64'd0);
        chk("rma_idle", 64'(req_ready_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
